// File: rtl/adc_sample_scheduler.sv
// ADC sample scheduler: paced start requests to an ADC driver, data-ready edge capture,
// level/edge trigger with post-trigger sample count. State is visible through busy_o/done_o.
module adc_sample_scheduler #(
    parameter int PER_W = 16,
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic [1:0]       mode_i,
    input  logic [PER_W-1:0] period_i,
    input  logic [9:0]       trig_level_i,
    input  logic             trig_edge_i,
    input  logic             trig_chan_i,
    input  logic [CNT_W-1:0] post_count_i,
    output logic             start_sample_o,
    output logic             channel_num_o,
    input  logic             adc_data_ready_i,
    input  logic [9:0]       adc_data_i,
    output logic             sample_valid_o,
    output logic [9:0]       sample_data_o,
    output logic             sample_chan_o,
    output logic             triggered_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t           state_q;
    logic [PER_W-1:0] per_cnt_q;
    logic             start_q, chan_q, ptr_q, rdy_prev_q;
    logic             valid_q, schan_q, trig_q, done_q, ovr_q;
    logic [9:0]       data_q, prev_data_q;
    logic             prev_valid_q;
    logic [CNT_W-1:0] post_cnt_q;

    logic             busy, tick, rdy_edge, chan_sel, rise_hit, fall_hit, trig_hit;
    logic [PER_W-1:0] per_reload;
    logic [CNT_W-1:0] post_nxt;

    assign busy       = (state_q == S_ARMED) || (state_q == S_POST);
    assign tick       = busy && (per_cnt_q == '0);
    // Edge is only meaningful while a conversion we requested is outstanding.
    assign rdy_edge   = start_q && !rdy_prev_q && adc_data_ready_i;
    assign per_reload = (period_i < PER_W'(2)) ? PER_W'(1) : period_i - PER_W'(1);
    assign post_nxt   = post_cnt_q + CNT_W'(1);

    always_comb begin
        chan_sel = 1'b0;
        case (mode_i)
            2'b01:   chan_sel = 1'b1;
            2'b10:   chan_sel = ptr_q;
            default: chan_sel = 1'b0;
        endcase
    end

    assign rise_hit = (prev_data_q < trig_level_i) && (adc_data_i >= trig_level_i);
    assign fall_hit = (prev_data_q > trig_level_i) && (adc_data_i <= trig_level_i);
    assign trig_hit = (state_q == S_ARMED) && prev_valid_q && (chan_q == trig_chan_i) &&
                      (trig_edge_i ? rise_hit : fall_hit);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            per_cnt_q    <= '0;
            start_q      <= 1'b0;
            chan_q       <= 1'b0;
            ptr_q        <= 1'b0;
            rdy_prev_q   <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            schan_q      <= 1'b0;
            trig_q       <= 1'b0;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            prev_data_q  <= '0;
            prev_valid_q <= 1'b0;
            post_cnt_q   <= '0;
        end else begin
            rdy_prev_q <= adc_data_ready_i;
            valid_q    <= 1'b0;
            if (abort_i) begin
                state_q <= S_IDLE;
                start_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (arm_i) begin
                            state_q      <= S_ARMED;
                            trig_q       <= 1'b0;
                            done_q       <= 1'b0;
                            ovr_q        <= 1'b0;
                            post_cnt_q   <= '0;
                            prev_valid_q <= 1'b0;
                            ptr_q        <= 1'b0;
                            per_cnt_q    <= '0;
                            start_q      <= 1'b0;
                        end
                    end
                    default: begin
                        per_cnt_q <= tick ? per_reload : per_cnt_q - PER_W'(1);
                        // A tick can only launch when nothing is outstanding, so it never
                        // collides with the edge-detect branch below on start_q.
                        if (tick) begin
                            if (start_q) begin
                                ovr_q <= 1'b1;
                            end else begin
                                start_q <= 1'b1;
                                chan_q  <= chan_sel;
                            end
                        end
                        if (rdy_edge) begin
                            start_q <= 1'b0;
                            valid_q <= 1'b1;
                            data_q  <= adc_data_i;
                            schan_q <= chan_q;
                            ptr_q   <= ~ptr_q;
                            if (chan_q == trig_chan_i) begin
                                prev_valid_q <= 1'b1;
                                prev_data_q  <= adc_data_i;
                            end
                            if (trig_hit) begin
                                trig_q     <= 1'b1;
                                post_cnt_q <= '0;
                                if (post_count_i == '0) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= S_POST;
                                end
                            end else if (state_q == S_POST) begin
                                post_cnt_q <= post_nxt;
                                if (post_nxt == post_count_i) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign start_sample_o = start_q;
    assign channel_num_o  = chan_q;
    assign sample_valid_o = valid_q;
    assign sample_data_o  = data_q;
    assign sample_chan_o  = schan_q;
    assign triggered_o    = trig_q;
    assign busy_o         = busy;
    assign done_o         = done_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a latency-programmable ADC driver model.
module tb_adc_sample_scheduler;
    localparam int PER_W = 16;
    localparam int CNT_W = 10;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             arm_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [1:0]       mode_i = 2'b00;
    logic [PER_W-1:0] period_i = 16'd20;
    logic [9:0]       trig_level_i = 10'd1023;
    logic             trig_edge_i = 1'b1;
    logic             trig_chan_i = 1'b0;
    logic [CNT_W-1:0] post_count_i = 10'd3;
    logic             adc_data_ready_i;
    logic [9:0]       adc_data_i;
    logic             start_sample_o, channel_num_o, sample_valid_o, sample_chan_o;
    logic [9:0]       sample_data_o;
    logic             triggered_o, busy_o, done_o, overrun_o;

    adc_sample_scheduler #(.PER_W(PER_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .arm_i(arm_i), .abort_i(abort_i),
        .mode_i(mode_i), .period_i(period_i), .trig_level_i(trig_level_i),
        .trig_edge_i(trig_edge_i), .trig_chan_i(trig_chan_i), .post_count_i(post_count_i),
        .start_sample_o(start_sample_o), .channel_num_o(channel_num_o),
        .adc_data_ready_i(adc_data_ready_i), .adc_data_i(adc_data_i),
        .sample_valid_o(sample_valid_o), .sample_data_o(sample_data_o),
        .sample_chan_o(sample_chan_o), .triggered_o(triggered_o), .busy_o(busy_o),
        .done_o(done_o), .overrun_o(overrun_o)
    );

    // clock / cycle counter
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ADC driver model: ready rises lat clocks after start is seen, drops when start drops
    int         lat = 12;
    logic       idx_clr = 1'b1;
    logic [3:0] idx = '0;
    int         lat_cnt = 0;
    logic [9:0] data_tab [16];
    always @(posedge clk_i) begin
        if (idx_clr) idx <= '0;
        if (!start_sample_o) begin
            adc_data_ready_i <= 1'b0;
            lat_cnt          <= 0;
        end else if (!adc_data_ready_i) begin
            if (lat_cnt == lat - 1) begin
                adc_data_ready_i <= 1'b1;
                adc_data_i       <= data_tab[idx];
                idx              <= idx + 4'd1;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    // monitor: log start rises, channel changes while start high, and every sample strobe
    logic       start_prev = 1'b0, chan_prev = 1'b0;
    int         chan_err = 0;
    int         rise_q[$], v_cyc_q[$];
    logic [9:0] v_data_q[$];
    logic       v_chan_q[$], v_trig_q[$], v_done_q[$], v_busy_q[$];
    always @(negedge clk_i) begin
        if (start_sample_o && !start_prev) rise_q.push_back(cyc);
        if (start_sample_o && start_prev && (channel_num_o != chan_prev)) chan_err++;
        if (sample_valid_o) begin
            v_cyc_q.push_back(cyc);
            v_data_q.push_back(sample_data_o);
            v_chan_q.push_back(sample_chan_o);
            v_trig_q.push_back(triggered_o);
            v_done_q.push_back(done_o);
            v_busy_q.push_back(busy_o);
        end
        start_prev = start_sample_o;
        chan_prev  = channel_num_o;
    end

    logic [17:0] outs;
    assign outs = {start_sample_o, channel_num_o, sample_valid_o, sample_data_o, sample_chan_o,
                   triggered_o, busy_o, done_o, overrun_o};

    // scoreboard
    int         total = 0, bad = 0;
    int         r_base, v_base, e_base, n;
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_test(input logic [1:0] m, input int per, input int l, input int lvl,
                              input logic edg, input logic tch, input int post);
        mode_i = m; period_i = PER_W'(per); lat = l; trig_level_i = 10'(lvl);
        trig_edge_i = edg; trig_chan_i = tch; post_count_i = CNT_W'(post);
        idx_clr = 1'b1;
        @(negedge clk_i);
        idx_clr = 1'b0;
        r_base = rise_q.size(); v_base = v_data_q.size(); e_base = chan_err;
        arm_i = 1'b1;
        @(negedge clk_i);
        arm_i = 1'b0;
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic count_valids(input int lo, input int hi);
        n = 0;
        for (int i = v_base; i < v_cyc_q.size(); i++)
            if (v_cyc_q[i] >= lo && v_cyc_q[i] < hi) n++;
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clk_i);
        chk("reset_outputs", 32'(outs), 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("idle_not_busy", 32'(busy_o), 32'd0);

        // mode 00, period 20, latency 12
        for (int i = 0; i < 16; i++) data_tab[i] = 10'd100;
        start_test(2'b00, 20, 12, 1023, 1'b1, 1'b0, 3);
        chk("a_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 200 && rise_q.size() < r_base + 3; i++) @(negedge clk_i);
        chk("a_three_rises", 32'(rise_q.size() >= r_base + 3), 32'd1);
        chk("a_period1", 32'(rise_q[r_base+1] - rise_q[r_base]), 32'd20);
        chk("a_period2", 32'(rise_q[r_base+2] - rise_q[r_base+1]), 32'd20);
        count_valids(rise_q[r_base], rise_q[r_base+2]);
        chk("a_valid_per_period", 32'(n), 32'd2);
        chk("a_chan0", 32'(v_chan_q[v_base] | v_chan_q[v_base+1] | channel_num_o), 32'd0);
        do_abort();

        // mode 10 alternate, ramp data
        for (int i = 0; i < 16; i++) data_tab[i] = 10'(100 + i);
        start_test(2'b10, 20, 12, 1023, 1'b1, 1'b0, 3);
        for (int i = 0; i < 300 && v_data_q.size() < v_base + 4; i++) @(negedge clk_i);
        chk("b_four_samples", 32'(v_data_q.size() >= v_base + 4), 32'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(10'(100 + i));
        for (int i = 0; i < 4; i++) begin
            exp_v = exp_q.pop_front();
            chk($sformatf("b_data%0d", i), 32'(v_data_q[v_base+i]), 32'(exp_v));
            chk($sformatf("b_chan%0d", i), 32'(v_chan_q[v_base+i]), 32'(i % 2));
        end
        chk("b_chan_stable", 32'(chan_err - e_base), 32'd0);
        do_abort();

        // rising trigger at 512, post_count 3
        data_tab[0] = 10'd500; data_tab[1] = 10'd510; data_tab[2] = 10'd520;
        data_tab[3] = 10'd530; data_tab[4] = 10'd540; data_tab[5] = 10'd550;
        for (int i = 6; i < 16; i++) data_tab[i] = 10'd600;
        start_test(2'b00, 20, 12, 512, 1'b1, 1'b0, 3);
        for (int i = 0; i < 400 && !done_o; i++) @(negedge clk_i);
        chk("c_done", 32'(done_o), 32'd1);
        chk("c_busy_low", 32'(busy_o), 32'd0);
        repeat (60) @(negedge clk_i);
        chk("c_sample_count", 32'(v_data_q.size() - v_base), 32'd6);
        chk("c_start_low", 32'(start_sample_o), 32'd0);
        chk("c_no_trig_510", 32'(v_trig_q[v_base+1]), 32'd0);
        chk("c_trig_520", 32'(v_trig_q[v_base+2]), 32'd1);
        chk("c_data_520", 32'(v_data_q[v_base+2]), 32'd520);
        chk("c_not_done_540", 32'({v_done_q[v_base+4], v_busy_q[v_base+4]}), 32'd1);
        chk("c_done_550", 32'({v_done_q[v_base+5], v_busy_q[v_base+5]}), 32'd2);

        // overrun: period 10, latency 25 (re-arm from DONE)
        for (int i = 0; i < 16; i++) data_tab[i] = 10'd0;
        start_test(2'b00, 10, 25, 1023, 1'b1, 1'b0, 3);
        chk("d_done_cleared", 32'(done_o), 32'd0);
        chk("d_trig_cleared", 32'(triggered_o), 32'd0);
        for (int i = 0; i < 200 && rise_q.size() < r_base + 2; i++) @(negedge clk_i);
        chk("d_two_rises", 32'(rise_q.size() >= r_base + 2), 32'd1);
        chk("d_rise_gap", 32'(rise_q[r_base+1] - rise_q[r_base]), 32'd30);
        chk("d_overrun", 32'(overrun_o), 32'd1);
        count_valids(rise_q[r_base], rise_q[r_base+1]);
        chk("d_one_sample", 32'(n), 32'd1);
        do_abort();

        // abort together with arm on the data-ready edge
        start_test(2'b00, 20, 12, 1023, 1'b1, 1'b0, 3);
        chk("e_overrun_cleared", 32'(overrun_o), 32'd0);
        for (int i = 0; i < 100 && !(adc_data_ready_i && start_sample_o); i++) @(negedge clk_i);
        chk("e_edge_reached", 32'(adc_data_ready_i && start_sample_o), 32'd1);
        abort_i = 1'b1; arm_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0; arm_i = 1'b0;
        chk("e_after_abort", 32'({busy_o, start_sample_o, sample_valid_o, done_o}), 32'd0);
        repeat (40) @(negedge clk_i);
        chk("e_no_sample", 32'(v_data_q.size() - v_base), 32'd0);
        abort_i = 1'b1; arm_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0; arm_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("e_abort_beats_arm", 32'({busy_o, start_sample_o}), 32'd0);

        // reset during POST, then re-arm
        data_tab[0] = 10'd500; data_tab[1] = 10'd510; data_tab[2] = 10'd520;
        data_tab[3] = 10'd530; data_tab[4] = 10'd540; data_tab[5] = 10'd550;
        for (int i = 6; i < 16; i++) data_tab[i] = 10'd600;
        start_test(2'b00, 20, 12, 512, 1'b1, 1'b0, 3);
        for (int i = 0; i < 300 && !triggered_o; i++) @(negedge clk_i);
        chk("f_in_post", 32'({triggered_o, busy_o}), 32'd3);
        repeat (5) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        chk("f_reset_outputs", 32'(outs), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("f_post_reset_idle", 32'(outs), 32'd0);
        start_test(2'b00, 20, 12, 512, 1'b1, 1'b0, 3);
        for (int i = 0; i < 400 && !done_o; i++) @(negedge clk_i);
        @(negedge clk_i);
        chk("f_rearm_done", 32'(done_o), 32'd1);
        chk("f_rearm_count", 32'(v_data_q.size() - v_base), 32'd6);
        chk("f_rearm_trig", 32'(v_trig_q[v_base+2]), 32'd1);

        // falling trigger at equality, post_count 0 finishes on the trigger sample
        data_tab[0] = 10'd320; data_tab[1] = 10'd310; data_tab[2] = 10'd300;
        for (int i = 3; i < 16; i++) data_tab[i] = 10'd290;
        start_test(2'b00, 20, 12, 300, 1'b0, 1'b0, 0);
        for (int i = 0; i < 300 && !done_o; i++) @(negedge clk_i);
        repeat (30) @(negedge clk_i);
        chk("g_count", 32'(v_data_q.size() - v_base), 32'd3);
        chk("g_no_trig_310", 32'({v_trig_q[v_base+1], v_done_q[v_base+1]}), 32'd0);
        chk("g_trig_done_300", 32'({v_trig_q[v_base+2], v_done_q[v_base+2]}), 32'd3);
        chk("g_busy_low", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_sample_scheduler.md
ADC_SAMPLE_SCHEDULER -- requirements
Module: adc_sample_scheduler

Interface
REQ-001 SHALL have parameter PER_W, default 16, width of sample-period count.
REQ-002 SHALL have parameter CNT_W, default 10, width of post-trigger sample count.
REQ-003 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  system clock; all other inputs synchronous to it
- rst_n_i  in  1  asynchronous active-low reset
- arm_i  in  1  pulse: start capture
- abort_i  in  1  pulse: cancel capture
- mode_i  in  2  00 CH0 only, 01 CH1 only, 10 alternate, 11 same as 00
- period_i  in  PER_W  clocks between start_sample_o rising edges
- trig_level_i  in  10  trigger threshold
- trig_edge_i  in  1  1 rising, 0 falling
- trig_chan_i  in  1  channel watched for trigger
- post_count_i  in  CNT_W  samples to take after trigger sample
- start_sample_o  out  1  ADC driver start request (level)
- channel_num_o  out  1  ADC channel select
- adc_data_ready_i  in  1  ADC driver data-ready level
- adc_data_i  in  10  ADC driver result
- sample_valid_o  out  1  one-cycle sample strobe
- sample_data_o  out  10  captured sample
- sample_chan_o  out  1  channel of sample_data_o
- triggered_o  out  1  trigger seen this capture (sticky)
- busy_o  out  1  state is ARMED or POST
- done_o  out  1  capture complete (sticky until next arm)
- overrun_o  out  1  sticky: period tick missed

Function
REQ-004 SHALL implement states IDLE, ARMED, POST, DONE; busy_o = (ARMED or POST).
REQ-005 SHALL go IDLE/DONE -> ARMED on arm_i; arm_i while busy SHALL be ignored.
REQ-006 SHALL on arm clear triggered_o, done_o, overrun_o, post counter, prev-sample-valid flag; alternate channel pointer SHALL reset to CH0.
REQ-007 SHALL run a period counter while busy; first tick the cycle after arm accepted, then every max(period_i,2) clocks.
REQ-008 SHALL on tick with no conversion pending drive start_sample_o high next cycle, holding until rising edge of adc_data_ready_i is detected.
REQ-009 SHALL, on tick while conversion pending, skip that tick and set overrun_o.
REQ-010 SHALL keep channel_num_o stable while start_sample_o is high; channel = CH0, CH1, or pointer in alternate mode, pointer toggling after each completed sample.
REQ-011 SHALL detect data-ready rising edge with a registered copy (prev=0, cur=1); start_sample_o SHALL drop the same cycle detection registers.
REQ-012 SHALL pulse sample_valid_o for exactly one cycle, the cycle after edge detection, with sample_data_o = adc_data_i captured at detection and sample_chan_o = channel used; data/chan hold until next sample.
REQ-013 SHALL in ARMED evaluate trigger only on samples of trig_chan_i with prev valid: rising = prev < level and cur >= level; falling = prev > level and cur <= level; unsigned 10-bit compare.
REQ-014 SHALL on trigger set triggered_o, go POST, post counter = 0; trigger sample itself is emitted and not counted.
REQ-015 SHALL in POST increment post counter per emitted sample (any channel); at count == post_count_i go DONE; post_count_i = 0 SHALL go DONE straight from ARMED on trigger sample.
REQ-016 SHALL in DONE set done_o, hold start_sample_o low, ignore further adc_data_ready_i edges.
REQ-017 SHALL on abort_i go IDLE from any state next cycle, drop start_sample_o, suppress pending sample_valid_o, leave done_o clear; abort_i and arm_i same cycle: abort wins.
REQ-018 SHALL treat period_i, mode_i, trig_* as sampled live; changing mode_i mid-conversion SHALL not alter channel_num_o until start_sample_o falls.

Reset
REQ-019 SHALL on rst_n_i low asynchronously force IDLE and all outputs 0, all counters 0, prev-valid 0; release synchronous to clk_i.
REQ-020 SHALL restart cleanly when reset asserts mid-conversion; first post-reset data-ready edge SHALL be ignored unless armed.

Verification
REQ-021 mode 00, period 20, ADC model ready after 12 clk -> start_sample_o rises every 20 clk, channel_num_o=0, one sample_valid_o per period.
REQ-022 mode 10, ramp data -> sample_chan_o sequence 0,1,0,1; channel_num_o never changes while start high.
REQ-023 rising, level 512, trig_chan 0, samples 500,510,520, post_count 3 -> triggered_o at 520, done_o after 3 more samples, busy_o falls same cycle.
REQ-024 period 10, ADC ready after 25 clk -> overrun_o set, ticks skipped, no double start.
REQ-025 abort_i mid-conversion, then arm_i same cycle as abort_i -> state IDLE, start_sample_o 0, no sample_valid_o, done_o 0.
REQ-026 rst_n_i low during POST -> all outputs 0 immediately; re-arm captures normally.
